// File: rtl/fma64_align_shift_arb.sv
// -----------------------------------------------------------------------------
// fma64_align_shift_arb
//
// Shared right-shift alignment unit. Two requesters (for example the FMA
// addend-alignment path and the FADD small-operand path) compete for a
// single 2-stage pipeline. The pipeline right-shifts a 64-bit mantissa by
// 0..63 and reports the guard bit and the sticky bit of the bits shifted out.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid_i/ready_o     requester N handshake (N = 0, 1)
//   reqN_mant_i              requester N mantissa (64 bits)
//   reqN_rsh_num_i           requester N right-shift amount (0..63)
//   reqN_tag_i               requester N opaque tag (TAG_W bits)
//   out_valid_o/ready_i      result handshake
//   out_mant_o               mant >> rsh_num
//   out_guard_o              mant[rsh_num-1], 0 when rsh_num == 0
//   out_sticky_o             |mant[rsh_num-2:0], 0 when rsh_num < 2
//   out_src_o                index of the requester that issued the result
//   out_tag_o                tag of the result
//   busy_o                   some pipeline stage holds valid data
// -----------------------------------------------------------------------------
module fma64_align_shift_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [63:0]      req0_mant_i,
    input  logic [5:0]       req0_rsh_num_i,
    input  logic [TAG_W-1:0] req0_tag_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [63:0]      req1_mant_i,
    input  logic [5:0]       req1_rsh_num_i,
    input  logic [TAG_W-1:0] req1_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [63:0]      out_mant_o,
    output logic             out_guard_o,
    output logic             out_sticky_o,
    output logic             out_src_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             busy_o
);

    // Round-robin pointer: 0 means requester 0 wins a tie.
    logic             r_prio;

    logic             r_s1_valid;
    logic [63:0]      r_s1_mant;
    logic [5:0]       r_s1_rsh;
    logic             r_s1_src;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [63:0]      r_s2_mant;
    logic             r_s2_guard;
    logic             r_s2_sticky;
    logic             r_s2_src;
    logic [TAG_W-1:0] r_s2_tag;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_s2_can_accept;
    logic             w_s1_can_accept;
    logic             w_hs;
    logic [63:0]      w_lost_mask;
    logic [63:0]      w_guard_sel;
    logic [63:0]      w_shifted;
    logic             w_guard;
    logic             w_sticky;

    // ---------------- arbitration and flow control ----------------
    assign w_grant0 = req0_valid_i & (~req1_valid_i | ~r_prio);
    assign w_grant1 = req1_valid_i & (~req0_valid_i | r_prio);

    // Ready is combinational from out_ready_i so a full pipeline can
    // drain, advance and refill in the same cycle.
    assign w_s2_can_accept = ~r_s2_valid | out_ready_i;
    assign w_s1_can_accept = ~r_s1_valid | w_s2_can_accept;

    assign req0_ready_o = w_grant0 & w_s1_can_accept;
    assign req1_ready_o = w_grant1 & w_s1_can_accept;
    assign w_hs         = req0_ready_o | req1_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_hs) begin
            // Priority passes to the requester that lost this round.
            r_prio <= w_grant0;
        end
    end

    // ---------------- stage S1: capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mant  <= '0;
            r_s1_rsh   <= '0;
            r_s1_src   <= 1'b0;
            r_s1_tag   <= '0;
        end else if (w_hs) begin
            r_s1_valid <= 1'b1;
            r_s1_mant  <= w_grant1 ? req1_mant_i    : req0_mant_i;
            r_s1_rsh   <= w_grant1 ? req1_rsh_num_i : req0_rsh_num_i;
            r_s1_src   <= w_grant1;
            r_s1_tag   <= w_grant1 ? req1_tag_i     : req0_tag_i;
        end else if (w_s2_can_accept) begin
            r_s1_valid <= 1'b0;
        end
    end

    // ---------------- stage S2: compute ----------------
    // w_lost_mask marks every bit shifted out; w_guard_sel marks the
    // highest of them (the guard position). Sticky covers the rest.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_mask
            assign w_lost_mask[gi] = (7'(gi) < {1'b0, r_s1_rsh});
            assign w_guard_sel[gi] = (7'(gi + 1) == {1'b0, r_s1_rsh});
        end
    endgenerate

    assign w_shifted = r_s1_mant >> r_s1_rsh;
    assign w_guard   = |(r_s1_mant & w_guard_sel);
    assign w_sticky  = |(r_s1_mant & w_lost_mask & ~w_guard_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_mant   <= '0;
            r_s2_guard  <= 1'b0;
            r_s2_sticky <= 1'b0;
            r_s2_src    <= 1'b0;
            r_s2_tag    <= '0;
        end else if (w_s2_can_accept) begin
            r_s2_valid <= r_s1_valid;
            // Data only moves with a valid operand, so a stalled or
            // emptied S2 keeps its fields steady.
            if (r_s1_valid) begin
                r_s2_mant   <= w_shifted;
                r_s2_guard  <= w_guard;
                r_s2_sticky <= w_sticky;
                r_s2_src    <= r_s1_src;
                r_s2_tag    <= r_s1_tag;
            end
        end
    end

    assign out_valid_o  = r_s2_valid;
    assign out_mant_o   = r_s2_mant;
    assign out_guard_o  = r_s2_guard;
    assign out_sticky_o = r_s2_sticky;
    assign out_src_o    = r_s2_src;
    assign out_tag_o    = r_s2_tag;
    assign busy_o       = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_fma64_align_shift_arb.sv
// -----------------------------------------------------------------------------
// tb_fma64_align_shift_arb
//
// Directed phases (reset, fairness, arithmetic boundaries, backpressure,
// full throughput, mid-flight reset) followed by a randomized phase. A
// behavioural model (in-order queue of accepted operands with acceptance
// cycle stamps) predicts ready, valid, busy and result fields every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fma64_align_shift_arb;

    logic        clk;
    logic        rst;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [63:0] req0_mant_i, req1_mant_i;
    logic [5:0]  req0_rsh_num_i, req1_rsh_num_i;
    logic [3:0]  req0_tag_i, req1_tag_i;
    logic        out_valid_o, out_ready_i;
    logic [63:0] out_mant_o;
    logic        out_guard_o, out_sticky_o, out_src_o;
    logic [3:0]  out_tag_o;
    logic        busy_o;

    fma64_align_shift_arb #(.TAG_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid_i   (req0_valid_i),
        .req0_ready_o   (req0_ready_o),
        .req0_mant_i    (req0_mant_i),
        .req0_rsh_num_i (req0_rsh_num_i),
        .req0_tag_i     (req0_tag_i),
        .req1_valid_i   (req1_valid_i),
        .req1_ready_o   (req1_ready_o),
        .req1_mant_i    (req1_mant_i),
        .req1_rsh_num_i (req1_rsh_num_i),
        .req1_tag_i     (req1_tag_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_mant_o     (out_mant_o),
        .out_guard_o    (out_guard_o),
        .out_sticky_o   (out_sticky_o),
        .out_src_o      (out_src_o),
        .out_tag_o      (out_tag_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [63:0] mant;
        logic [5:0]  rsh;
        logic        src;
        logic [3:0]  tag;
        int          t;
    } item_t;

    item_t q[$];
    bit    mprio = 1'b0;
    bit    hs0_s = 1'b0;
    bit    hs1_s = 1'b0;

    function automatic logic f_guard(input logic [63:0] m, input logic [5:0] r);
        int idx;
        if (r == 6'd0) return 1'b0;
        idx = int'(r) - 1;
        return m[idx];
    endfunction

    function automatic logic f_sticky(input logic [63:0] m, input logic [5:0] r);
        logic [63:0] below;
        if (r < 6'd2) return 1'b0;
        below = (64'd1 << (r - 6'd1)) - 64'd1;
        return |(m & below);
    endfunction

    initial begin : compare
        int    n;
        bit    vis, s1v, s2v, can, g0, g1, e_r0, e_r1;
        item_t it;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                mprio = 1'b0;
                hs0_s = 1'b0;
                hs1_s = 1'b0;
                chk("rst_out_valid", 64'(out_valid_o), 64'd0);
                chk("rst_busy", 64'(busy_o), 64'd0);
            end else begin
                n   = q.size();
                vis = (n > 0) && (q[0].t + 2 <= cyc);
                s2v = vis;
                s1v = (n == 2) || (n == 1 && !vis);
                can = !s1v || !s2v || out_ready_i;
                g0  = req0_valid_i && (!req1_valid_i || !mprio);
                g1  = req1_valid_i && (!req0_valid_i || mprio);
                e_r0 = g0 && can;
                e_r1 = g1 && can;
                chk("ready0", 64'(req0_ready_o), 64'(e_r0));
                chk("ready1", 64'(req1_ready_o), 64'(e_r1));
                chk("out_valid", 64'(out_valid_o), 64'(vis));
                chk("busy", 64'(busy_o), 64'(n > 0));
                if (vis && out_valid_o) begin
                    chk("out_mant", out_mant_o, q[0].mant >> q[0].rsh);
                    chk("out_guard", 64'(out_guard_o), 64'(f_guard(q[0].mant, q[0].rsh)));
                    chk("out_sticky", 64'(out_sticky_o), 64'(f_sticky(q[0].mant, q[0].rsh)));
                    chk("out_src", 64'(out_src_o), 64'(q[0].src));
                    chk("out_tag", 64'(out_tag_o), 64'(q[0].tag));
                    if (out_ready_i) begin
                        $display("result src=%0d tag=%0h rsh=%0d mant=%h g=%0d s=%0d",
                                 out_src_o, out_tag_o, q[0].rsh, out_mant_o, out_guard_o, out_sticky_o);
                    end
                end
                if (vis && out_ready_i) void'(q.pop_front());
                if (e_r0) begin
                    it = '{mant: req0_mant_i, rsh: req0_rsh_num_i, src: 1'b0, tag: req0_tag_i, t: cyc};
                    q.push_back(it);
                    mprio = 1'b1;
                end else if (e_r1) begin
                    it = '{mant: req1_mant_i, rsh: req1_rsh_num_i, src: 1'b1, tag: req1_tag_i, t: cyc};
                    q.push_back(it);
                    mprio = 1'b0;
                end
                hs0_s = req0_valid_i && req0_ready_o;
                hs1_s = req1_valid_i && req1_ready_o;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [5:0] rand_rsh();
        logic [5:0] edges [4] = '{6'd0, 6'd1, 6'd2, 6'd63};
        if ($urandom_range(3) == 0) return edges[$urandom_range(3)];
        return 6'($urandom_range(63));
    endfunction

    task automatic new0();
        req0_mant_i    = {$urandom, $urandom};
        req0_rsh_num_i = rand_rsh();
        req0_tag_i     = 4'($urandom);
    endtask

    task automatic new1();
        req1_mant_i    = {$urandom, $urandom};
        req1_rsh_num_i = rand_rsh();
        req1_tag_i     = 4'($urandom);
    endtask

    // Drop valids only after their handshake, then let the pipe empty.
    task automatic idle();
        for (int k = 0; k < 50 && (req0_valid_i || req1_valid_i); k++) begin
            @(posedge clk); #1;
            if (hs0_s) req0_valid_i = 1'b0;
            if (hs1_s) req1_valid_i = 1'b0;
        end
        chk("idle_drain", 64'(req0_valid_i | req1_valid_i), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One request, no backpressure: result must appear two cycles later.
    task automatic single(input bit src, input logic [63:0] m, input logic [5:0] r,
                          input logic [3:0] tag, input logic [63:0] e_mant,
                          input bit e_g, input bit e_s);
        if (src) begin
            req1_valid_i = 1'b1; req1_mant_i = m; req1_rsh_num_i = r; req1_tag_i = tag;
        end else begin
            req0_valid_i = 1'b1; req0_mant_i = m; req0_rsh_num_i = r; req0_tag_i = tag;
        end
        @(negedge clk);
        chk("lit_ready", 64'(src ? req1_ready_o : req0_ready_o), 64'd1);
        @(posedge clk); #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("lit_valid", 64'(out_valid_o), 64'd1);
        chk("lit_mant", out_mant_o, e_mant);
        chk("lit_guard", 64'(out_guard_o), 64'(e_g));
        chk("lit_sticky", 64'(out_sticky_o), 64'(e_s));
        chk("lit_src", 64'(out_src_o), 64'(src));
        chk("lit_tag", 64'(out_tag_o), 64'(tag));
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int          cnt;
        logic [63:0] snap_mant;
        logic [3:0]  snap_tag;
        bit          have_snap;

        rst = 1'b1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_mant_i = '0; req0_rsh_num_i = '0; req0_tag_i = '0;
        req1_mant_i = '0; req1_rsh_num_i = '0; req1_tag_i = '0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid_o), 64'd0);
        chk("reset_out_mant", out_mant_o, 64'd0);
        chk("reset_out_flags", {61'd0, out_guard_o, out_sticky_o, out_src_o}, 64'd0);
        chk("reset_out_tag", 64'(out_tag_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        rst = 1'b0;

        // Round-robin fairness straight out of reset.
        req0_valid_i = 1'b1; new0();
        req1_valid_i = 1'b1; new1();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_ready0", 64'(req0_ready_o), 64'(i % 2 == 0));
            chk("rr_ready1", 64'(req1_ready_o), 64'(i % 2 == 1));
            @(posedge clk); #1;
            if (hs0_s) new0();
            if (hs1_s) new1();
        end
        idle();

        // Arithmetic boundaries.
        single(1'b0, 64'h8000_0000_0000_0001, 6'd0, 4'h3, 64'h8000_0000_0000_0001, 1'b0, 1'b0);
        single(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd1, 4'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        single(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd2, 4'h2, 64'h3FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        single(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 4'h7, 64'd1, 1'b1, 1'b1);
        single(1'b1, 64'h4000_0000_0000_0000, 6'd63, 4'h5, 64'd0, 1'b1, 1'b0);
        idle();

        // Backpressure: req1 streams with the consumer stalled.
        out_ready_i = 1'b0;
        req1_valid_i = 1'b1; new1();
        cnt = 0; have_snap = 1'b0; snap_mant = '0; snap_tag = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (req1_valid_i && req1_ready_o) cnt++;
            if (out_valid_o) begin
                if (have_snap) begin
                    chk("bp_hold_mant", out_mant_o, snap_mant);
                    chk("bp_hold_tag", 64'(out_tag_o), 64'(snap_tag));
                end
                snap_mant = out_mant_o; snap_tag = out_tag_o; have_snap = 1'b1;
            end
            @(posedge clk); #1;
            if (hs1_s) new1();
        end
        chk("bp_accepted", 64'(cnt), 64'd2);
        @(negedge clk);
        chk("bp_ready1_low", 64'(req1_ready_o), 64'd0);
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (hs1_s) new1();
        end
        idle();

        // Full throughput from requester 0.
        req0_valid_i = 1'b1; new0();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8)  chk("tp_ready0", 64'(req0_ready_o), 64'd1);
            if (i >= 2) chk("tp_out_valid", 64'(out_valid_o), 64'd1);
            if (i >= 1) chk("tp_busy", 64'(busy_o), 64'd1);
            @(posedge clk); #1;
            if (i < 7) new0();
            else req0_valid_i = 1'b0;
        end
        idle();

        // Reset while both stages hold data.
        out_ready_i = 1'b0;
        req0_valid_i = 1'b1; new0();
        repeat (3) begin
            @(posedge clk); #1;
            if (hs0_s) new0();
        end
        chk("mid_busy_before", 64'(busy_o), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        new0();
        req1_valid_i = 1'b1; new1();
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready0", 64'(req0_ready_o), 64'd1);
        chk("post_rst_ready1", 64'(req1_ready_o), 64'd0);
        @(posedge clk); #1;
        if (hs0_s) new0();
        if (hs1_s) new1();
        idle();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            out_ready_i = ($urandom_range(3) != 0);
            if (!req0_valid_i || hs0_s) begin
                req0_valid_i = ($urandom_range(2) != 0);
                new0();
            end
            if (!req1_valid_i || hs1_s) begin
                req1_valid_i = ($urandom_range(2) != 0);
                new1();
            end
        end
        out_ready_i = 1'b1;
        idle();
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
